axis_packet_arbiter: RTL and testbench
======================================

# axis_packet_arbiter

Packet-level arbiter that shares one downstream AXI-Stream among NUM_INPUTS upstream sources. A grant is held from the first beat of a packet until its tlast beat is accepted, so packets are never interleaved. The output passes through a single registered stage, and each beat is tagged with the index of its source. The block sits in front of shared sinks such as a MAC TX path or a DMA write port.

## Interface
Parameters:
- NUM_INPUTS, 2: number of requesting streams, 2..16.
- AXIS_BYTES, 1: tdata width in bytes.
- AXIS_USER_BITS, 1: tuser width.
- Derived constant ID_BITS = max(1, $clog2(NUM_INPUTS)).

Ports:
- clk  input  1  rising-edge clock.
- areset  input  1  asynchronous reset, active-high.
- axis_i_tready  output  NUM_INPUTS  per-input ready.
- axis_i_tvalid  input  NUM_INPUTS  per-input valid.
- axis_i_tlast  input  NUM_INPUTS  per-input last.
- axis_i_tdata  input  NUM_INPUTS*AXIS_BYTES*8  flattened; input k occupies slice k.
- axis_i_tuser  input  NUM_INPUTS*AXIS_USER_BITS  flattened, same layout as tdata.
- axis_o_tready  input  1  downstream ready.
- axis_o_tvalid  output  1  downstream valid.
- axis_o_tlast  output  1  downstream last.
- axis_o_tdata  output  AXIS_BYTES*8  downstream data.
- axis_o_tuser  output  AXIS_USER_BITS  downstream user.
- axis_o_tid  output  ID_BITS  source index of the current output beat.

## Operation
- State machine with two states, IDLE and LOCKED.
- **IDLE:**
  - All axis_i_tready are 0.
  - If any axis_i_tvalid is set, the selector picks a winner, registers it in sel, and moves to LOCKED at the next edge.
  - If no tvalid is set, the state stays IDLE.
- **LOCKED:**
  - axis_i_tready[sel] equals the output-stage ready, which is (!axis_o_tvalid || axis_o_tready). All other treadys are 0.
  - The selected input's tdata, tuser and tlast, with tid = sel, are muxed into the output register.
  - When the beat accepted from input sel has tlast=1, the state returns to IDLE on that edge and the pointer updates.
- Round-robin selection (default build):
  - The search starts at index ptr and wraps modulo NUM_INPUTS.
  - The pointer update is ptr <= sel+1, which wraps to 0 after NUM_INPUTS-1.
- The output register behaves as follows:
  - It loads on accept.
  - It clears tvalid when axis_o_tready=1 and no new beat is being loaded.
  - It holds tdata, tuser, tlast and tid stable while tvalid=1 and tready=0.
- A source that deasserts tvalid mid-packet stalls the arbiter in LOCKED. The grant is never revoked before tlast.
- A single-beat packet (tlast on the first beat) is legal and takes exactly one LOCKED beat.

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - state IDLE, ptr 0, sel 0;
  - axis_o_tvalid, tlast, tdata, tuser and tid all 0;
  - all axis_i_tready 0.
- Reset mid-packet drops the packet immediately. axis_o_tvalid is 0 in the same cycle as reset assertion.
- Latency:
  - Request to first axis_i_tready is 1 cycle (the IDLE decision cycle).
  - Input accept to axis_o_tvalid is 1 cycle.
  - With an uncongested sink, the first output beat appears 2 cycles after tvalid rises.
- Throughput:
  - One beat per cycle within a packet while axis_o_tready=1.
  - There is one bubble cycle between packets.
- When requests arrive simultaneously, exactly one winner is chosen per IDLE cycle. A request never waits more than NUM_INPUTS-1 packets in round-robin mode.

## Configuration
- The macro is AXIS_ARB_ROUND_ROBIN_EN.
- Defined: round-robin selection with the rotating ptr described above.
- Undefined: fixed priority, where the lowest asserted index wins. The ptr register is not built and starvation of high indices is permitted.

## Structure
- Package axis_arb_pkg contains:
  - the state enum typedef (ARB_IDLE, ARB_LOCKED);
  - the ID_BITS helper function;
  - the function rr_select(req, ptr), which returns the winning index.
- One sub-module is used: axis_register instantiated as the output stage. Its tid is carried by widening tuser internally to AXIS_USER_BITS+ID_BITS and splitting it back out on the output.

## Test plan
- **Single-source packet:** NUM_INPUTS=4; input 2 sends a 3-beat packet with data 0x11,0x22,0x33 and axis_o_tready=1 → output beats 0x11,0x22,0x33 with tid=2, tlast only on 0x33, first output beat 2 cycles after tvalid.
- **Round-robin fairness:** all 4 inputs continuously send 1-beat packets → output tid sequence 0,1,2,3,0,1…, with one idle cycle between beats.
- **No interleaving under backpressure:** inputs 0 and 1 send 4-beat packets while axis_o_tready toggles 1,0,1,0 → all 4 beats of input 0 precede any beat of input 1, and output data is stable during every tready=0 cycle.
- **Source stall:** input 0 drops tvalid for 5 cycles mid-packet while input 1 is requesting → input 1 gets no tready until input 0's tlast is accepted.
- **Reset mid-packet:** areset is pulsed during beat 2 of a packet → axis_o_tvalid=0 and all treadys=0 immediately, and after release the next grant goes to the lowest requesting index (ptr=0).
- **Fixed priority:** build without AXIS_ARB_ROUND_ROBIN_EN; inputs 0 and 3 send back-to-back packets → input 3 is granted only while input 0 is not requesting.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state type and selection helpers
// for axis_packet_arbiter.
package axis_arb_pkg;

  localparam int ARB_MAX_IN = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef logic [3:0] arb_idx_t;

  function automatic int id_bits(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // First asserted request at or after ptr, wrapping modulo n.
  function automatic arb_idx_t rr_select(
    input logic [ARB_MAX_IN-1:0] req,
    input arb_idx_t              ptr,
    input int                    n
  );
    arb_idx_t w_win;
    logic     w_found;
    int       k;
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < ARB_MAX_IN; i++) begin
      k = (int'(ptr) + i) % n;
      if (!w_found && i < n && req[k[3:0]]) begin
        w_win   = arb_idx_t'(k);
        w_found = 1'b1;
      end
    end
    return w_win;
  endfunction

endpackage

// File: rtl/axis_register.sv
// axis_register: single-slot AXI-Stream register stage; accepts
// whenever the slot is empty or being drained this cycle.
module axis_register #(
  parameter int DW = 8,
  parameter int UW = 1
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  input  logic [UW-1:0] i_user,
  input  logic          i_last,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [UW-1:0] o_user,
  output logic          o_last
);

  logic          r_valid;
  logic          r_last;
  logic [DW-1:0] r_data;
  logic [UW-1:0] r_user;
  logic          w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_user  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_last  <= i_last;
      r_data  <= i_data;
      r_user  <= i_user;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_data  = r_data;
  assign o_user  = r_user;

endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-locked N:1 AXI-Stream arbiter with tid tagging.
// Define AXIS_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_INPUTS     = 2,
  parameter  int AXIS_BYTES     = 1,
  parameter  int AXIS_USER_BITS = 1,
  localparam int ID_BITS        = id_bits(NUM_INPUTS),
  localparam int DW             = AXIS_BYTES * 8,
  localparam int UW             = AXIS_USER_BITS
) (
  input  logic                     clk,
  input  logic                     areset,
  output logic [NUM_INPUTS-1:0]    axis_i_tready,
  input  logic [NUM_INPUTS-1:0]    axis_i_tvalid,
  input  logic [NUM_INPUTS-1:0]    axis_i_tlast,
  input  logic [NUM_INPUTS*DW-1:0] axis_i_tdata,
  input  logic [NUM_INPUTS*UW-1:0] axis_i_tuser,
  input  logic                     axis_o_tready,
  output logic                     axis_o_tvalid,
  output logic                     axis_o_tlast,
  output logic [DW-1:0]            axis_o_tdata,
  output logic [UW-1:0]            axis_o_tuser,
  output logic [ID_BITS-1:0]       axis_o_tid
);

  arb_state_t              r_state;
  logic [ID_BITS-1:0]      r_sel;
  logic [ARB_MAX_IN-1:0]   w_req;
  arb_idx_t                w_win;
  logic                    w_s_ready;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic                    w_load;
  logic                    w_acc;
  logic [DW-1:0]           w_sel_data;
  logic [UW-1:0]           w_sel_user;
  logic [UW+ID_BITS-1:0]   w_m_user;
  logic [NUM_INPUTS-1:0]   w_tready;

  always_comb begin
    w_req = '0;
    w_req[NUM_INPUTS-1:0] = axis_i_tvalid;
  end

`ifdef AXIS_ARB_ROUND_ROBIN_EN
  logic [ID_BITS-1:0] r_ptr;
  assign w_win = rr_select(w_req, arb_idx_t'(r_ptr), NUM_INPUTS);
`else
  assign w_win = rr_select(w_req, '0, NUM_INPUTS);
`endif

  assign w_sel_valid = axis_i_tvalid[r_sel];
  assign w_sel_last  = axis_i_tlast[r_sel];
  assign w_sel_data  = axis_i_tdata[r_sel*DW +: DW];
  assign w_sel_user  = axis_i_tuser[r_sel*UW +: UW];
  assign w_load      = (r_state == ARB_LOCKED) && w_sel_valid;
  assign w_acc       = w_load && w_s_ready;

  always_comb begin
    w_tready = '0;
    if (r_state == ARB_LOCKED) w_tready[r_sel] = w_s_ready;
  end

  assign axis_i_tready = w_tready;

  // Grant is held until the owner's tlast beat is accepted.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= ARB_IDLE;
      r_sel   <= '0;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
      r_ptr   <= '0;
`endif
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (|axis_i_tvalid) begin
            r_sel   <= w_win[ID_BITS-1:0];
            r_state <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (w_acc && w_sel_last) begin
            r_state <= ARB_IDLE;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
            r_ptr <= (r_sel == ID_BITS'(NUM_INPUTS - 1))
                   ? '0 : r_sel + 1'b1;
`endif
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // tid rides alongside tuser through the output stage.
  axis_register #(
    .DW (DW),
    .UW (UW + ID_BITS)
  ) u_out (
    .clk     (clk),
    .areset  (areset),
    .i_valid (w_load),
    .o_ready (w_s_ready),
    .i_data  (w_sel_data),
    .i_user  ({r_sel, w_sel_user}),
    .i_last  (w_sel_last),
    .o_valid (axis_o_tvalid),
    .i_ready (axis_o_tready),
    .o_data  (axis_o_tdata),
    .o_user  (w_m_user),
    .o_last  (axis_o_tlast)
  );

  assign {axis_o_tid, axis_o_tuser} = w_m_user;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: directed and random checks of the
// packet arbiter against a queue-based source/sink model.
module tb_axis_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int UW = 1;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic          l;
    logic [IW-1:0] id;
  } beat_t;

  logic            clk = 1'b0;
  logic            areset = 1'b1;
  logic [N-1:0]    i_tready;
  logic [N-1:0]    i_tvalid = '0;
  logic [N-1:0]    i_tlast = '0;
  logic [N*DW-1:0] i_tdata = '0;
  logic [N*UW-1:0] i_tuser = '0;
  logic            o_tready = 1'b0;
  logic            o_tvalid;
  logic            o_tlast;
  logic [DW-1:0]   o_tdata;
  logic [UW-1:0]   o_tuser;
  logic [IW-1:0]   o_tid;

  axis_packet_arbiter #(
    .NUM_INPUTS     (N),
    .AXIS_BYTES     (1),
    .AXIS_USER_BITS (UW)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .axis_i_tready (i_tready),
    .axis_i_tvalid (i_tvalid),
    .axis_i_tlast  (i_tlast),
    .axis_i_tdata  (i_tdata),
    .axis_i_tuser  (i_tuser),
    .axis_o_tready (o_tready),
    .axis_o_tvalid (o_tvalid),
    .axis_o_tlast  (o_tlast),
    .axis_o_tdata  (o_tdata),
    .axis_o_tuser  (o_tuser),
    .axis_o_tid    (o_tid)
  );

  always #5 clk = ~clk;

  // Source model: per-source beat queues, presented one beat at a time.
  beat_t src_q[N][$];
  bit    src_v[N];
  int    stall_cnt[N];
  int    stall_at[N];
  int    acc_cnt[N];
  int    rate[N];
  // Sink model: the beat (if any) sitting in the output stage.
  beat_t held[$];
  beat_t log_q[$];
  int    owner = -1;
  int    nextp = 0;
  int    cyc = 0;
  int    first_out = -1;
  int    rdy_pct = 100;
  bit    rdy_toggle = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int k, input int len,
                         input logic [7:0] d0, input logic [7:0] step);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d  = d0 + 8'(int'(step) * i);
      b.u  = UW'($urandom);
      b.l  = (i == len - 1);
      b.id = IW'(k);
      src_q[k].push_back(b);
    end
  endtask

  function automatic int pick();
    int start;
    start = 0;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
    start = nextp;
`endif
    for (int i = 0; i < N; i++)
      if (src_v[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = (held.size() != 0) || (owner >= 0);
    for (int k = 0; k < N; k++)
      if (src_q[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic cycle();
    int           acc;
    int           grant;
    bit           pop;
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < N; k++) begin
      if (stall_cnt[k] > 0) stall_cnt[k]--;
      else if (!src_v[k] && src_q[k].size() > 0 &&
               int'($urandom_range(99)) < rate[k]) src_v[k] = 1'b1;
      i_tvalid[k] = src_v[k];
      if (src_q[k].size() > 0) begin
        i_tdata[k*DW +: DW] = src_q[k][0].d;
        i_tuser[k*UW +: UW] = src_q[k][0].u;
        i_tlast[k]          = src_q[k][0].l;
      end else begin
        i_tdata[k*DW +: DW] = '0;
        i_tuser[k*UW +: UW] = '0;
        i_tlast[k]          = 1'b0;
      end
    end
    if (rdy_toggle) o_tready = (cyc % 2 == 0);
    else o_tready = (int'($urandom_range(99)) < rdy_pct);
    #1;
    exp_rdy = '0;
    if (owner >= 0 && (held.size() == 0 || o_tready))
      exp_rdy[owner] = 1'b1;
    chk("tready", 64'(i_tready), 64'(exp_rdy));
    chk("ovalid", 64'(o_tvalid), 64'(held.size() != 0));
    if (held.size() != 0)
      chk("obeat", 64'({o_tdata, o_tuser, o_tlast, o_tid}),
          64'(held[0]));
    if (o_tvalid && first_out < 0) first_out = cyc;
    if (o_tvalid && o_tready)
      log_q.push_back({o_tdata, o_tuser, o_tlast, o_tid});
    acc   = (owner >= 0 && src_v[owner] && exp_rdy[owner]) ? owner : -1;
    pop   = (held.size() != 0) && o_tready;
    grant = (owner < 0) ? pick() : -1;
    @(posedge clk);
    cyc++;
    if (pop) void'(held.pop_front());
    if (acc >= 0) begin
      held.push_back(src_q[acc].pop_front());
      src_v[acc] = 1'b0;
      acc_cnt[acc]++;
      if (acc_cnt[acc] == stall_at[acc]) stall_cnt[acc] = 5;
      if (held[held.size()-1].l) begin
        owner = -1;
        nextp = (acc + 1) % N;
      end
    end else if (grant >= 0) begin
      owner = grant;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    chk("drain", 64'(busy()), 64'(0));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #1;
    chk("rst_ovalid", 64'(o_tvalid), 64'(0));
    chk("rst_tready", 64'(i_tready), 64'(0));
    chk("rst_obeat", 64'({o_tdata, o_tuser, o_tlast, o_tid}), 64'(0));
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      src_v[k]     = 1'b0;
      stall_cnt[k] = 0;
      stall_at[k]  = -1;
      acc_cnt[k]   = 0;
      rate[k]      = 100;
    end
    i_tvalid = '0;
    held.delete();
    log_q.delete();
    owner      = -1;
    nextp      = 0;
    rdy_pct    = 100;
    rdy_toggle = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic chk_ids(input string tag, input int e[$]);
    chk({tag, "_n"}, 64'(log_q.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i < log_q.size())
        chk(tag, 64'(log_q[i].id), 64'(e[i]));
  endtask

  initial begin
    int t0;
    int e[$];
    @(negedge clk);
    do_reset();

    // Single-source 3-beat packet from input 2.
    add_pkt(2, 3, 8'h11, 8'h11);
    t0 = cyc;
    first_out = -1;
    drain(50);
    chk("b_latency", 64'(first_out - t0), 64'(2));
    chk("b_n", 64'(log_q.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      if (i < log_q.size()) begin
        chk("b_data", 64'(log_q[i].d), 64'(8'(17 * (i + 1))));
        chk("b_last", 64'(log_q[i].l), 64'(i == 2));
        chk("b_tid", 64'(log_q[i].id), 64'(2));
      end

    // All inputs continuously offering single-beat packets.
    do_reset();
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 3; p++) add_pkt(k, 1, 8'($urandom), 8'd0);
    drain(200);
    e.delete();
    for (int i = 0; i < 3 * N; i++) begin
`ifdef AXIS_ARB_ROUND_ROBIN_EN
      e.push_back(i % N);
`else
      e.push_back(i / 3);
`endif
    end
    chk_ids("c_order", e);

    // Two 4-beat packets under alternating downstream ready.
    do_reset();
    add_pkt(0, 4, 8'h40, 8'h01);
    add_pkt(1, 4, 8'h80, 8'h01);
    rdy_toggle = 1'b1;
    drain(200);
    rdy_toggle = 1'b0;
    e = '{0, 0, 0, 0, 1, 1, 1, 1};
    chk_ids("d_order", e);

    // Owner stalls for 5 cycles mid-packet while input 1 waits.
    do_reset();
    add_pkt(0, 4, 8'h10, 8'h01);
    add_pkt(1, 1, 8'hA5, 8'h00);
    stall_at[0] = 2;
    drain(200);
    e = '{0, 0, 0, 0, 1};
    chk_ids("e_order", e);

    // Reset while input 2 is mid-packet; pointer must restart at 0.
    do_reset();
    add_pkt(2, 1, 8'h01, 8'h00);
    add_pkt(2, 4, 8'h20, 8'h01);
    for (int i = 0; i < 50 && acc_cnt[2] < 2; i++) cycle();
    chk("f_reach", 64'(acc_cnt[2]), 64'(2));
    do_reset();
    add_pkt(1, 1, 8'h31, 8'h00);
    add_pkt(3, 1, 8'h33, 8'h00);
    drain(50);
    e = '{1, 3};
    chk_ids("f_order", e);

    // Inputs 0 and 3 with back-to-back packets.
    do_reset();
    for (int p = 0; p < 3; p++) add_pkt(0, 2, 8'(p * 16), 8'h01);
    for (int p = 0; p < 2; p++) add_pkt(3, 2, 8'(p * 16 + 8'h80), 8'h01);
    drain(200);
`ifdef AXIS_ARB_ROUND_ROBIN_EN
    e = '{0, 0, 3, 3, 0, 0, 3, 3, 0, 0};
`else
    e = '{0, 0, 0, 0, 0, 0, 3, 3, 3, 3};
`endif
    chk_ids("g_order", e);

    // Random traffic, stalls and backpressure.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rdy_pct = 50 + 20 * r;
      for (int k = 0; k < N; k++) begin
        rate[k]     = int'($urandom_range(100, 30));
        stall_at[k] = int'($urandom_range(8, 1));
        for (int p = 0; p < int'($urandom_range(6, 2)); p++)
          add_pkt(k, int'($urandom_range(5, 1)), 8'($urandom), 8'd3);
      end
      drain(4000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
